// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Two-digit multiplexed seven-segment scan controller. Key presses shift into
// a two-deep digit store (right = newest, left = previous). A four-state scan
// FSM alternates between the digits with a dark gap between visits, so that the
// shared decoder input (select) settles before the next anode turns on.
//
// Parameters
//   REFRESH_CYCLES : cycles each digit is lit per visit (2..65536)
//   BLANK_CYCLES   : cycles both digits are dark between visits (1..65536)
//
// Ports
//   int_osc   in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   key_valid in   one-cycle strobe: key_code holds a debounced key press
//   key_code  in   [3:0] hex value of the key
//   select    out  [3:0] registered hex value for the shared decoder
//   osc       out  [1:0] registered active-low digit enables
//                  (osc[0] = right digit, osc[1] = left digit)
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 24000,
  parameter int unsigned BLANK_CYCLES   = 480
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] select,
  output logic [1:0] osc
);

  typedef enum logic [1:0] {
    SHOW_R   = 2'd0,
    BLANK_RL = 2'd1,
    SHOW_L   = 2'd2,
    BLANK_LR = 2'd3
  } state_t;

  // Terminal dwell values; a state of N cycles counts 0..N-1.
  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_CYCLES - 1);
  localparam logic [15:0] BLANK_LAST   = 16'(BLANK_CYCLES - 1);

  localparam logic [1:0] OSC_RIGHT = 2'b10;
  localparam logic [1:0] OSC_LEFT  = 2'b01;
  localparam logic [1:0] OSC_DARK  = 2'b11;

  state_t      state;
  logic [15:0] dwell;
  logic [3:0]  right_dig;
  logic [3:0]  left_dig;
  logic        right_vld;
  logic        left_vld;
  logic        dwell_done;

  always_comb begin
    dwell_done = 1'b0;
    case (state)
      SHOW_R, SHOW_L:     dwell_done = (dwell == REFRESH_LAST);
      BLANK_RL, BLANK_LR: dwell_done = (dwell == BLANK_LAST);
      default:            dwell_done = 1'b0;
    endcase
  end

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state     <= SHOW_R;
      dwell     <= 16'd0;
      right_dig <= 4'h0;
      left_dig  <= 4'h0;
      right_vld <= 1'b0;
      left_vld  <= 1'b0;
      select    <= 4'h0;
      osc       <= OSC_DARK;
    end else begin
      // Key shift is independent of the scan, so a press landing on a state
      // transition neither gets lost nor disturbs the dwell timing.
      if (key_valid) begin
        left_dig  <= right_dig;
        left_vld  <= right_vld;
        right_dig <= key_code;
        right_vld <= 1'b1;
      end

      if (dwell_done) begin
        dwell <= 16'd0;
        case (state)
          SHOW_R:   state <= BLANK_RL;
          BLANK_RL: state <= SHOW_L;
          SHOW_L:   state <= BLANK_LR;
          BLANK_LR: state <= SHOW_R;
          default:  state <= SHOW_R;
        endcase
      end else begin
        dwell <= dwell + 16'd1;
      end

      // Outputs follow the current state one cycle later. Blank states already
      // point select at the digit about to be lit.
      case (state)
        SHOW_R: begin
          select <= right_dig;
          osc    <= right_vld ? OSC_RIGHT : OSC_DARK;
        end
        BLANK_RL: begin
          select <= left_dig;
          osc    <= OSC_DARK;
        end
        SHOW_L: begin
          select <= left_dig;
          osc    <= left_vld ? OSC_LEFT : OSC_DARK;
        end
        BLANK_LR: begin
          select <= right_dig;
          osc    <= OSC_DARK;
        end
        default: begin
          select <= 4'h0;
          osc    <= OSC_DARK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Self-checking bench for display_scan_ctrl with REFRESH_CYCLES=8 and
// BLANK_CYCLES=2. A reference model tracks the digit store and derives the scan
// phase from the number of clock edges since reset release.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int RC = 8;
  localparam int BC = 2;
  localparam int PERIOD = 2 * (RC + BC);

  logic       int_osc = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] select;
  logic [1:0] osc;

  display_scan_ctrl #(.REFRESH_CYCLES(RC), .BLANK_CYCLES(BC)) dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .key_valid(key_valid),
    .key_code (key_code),
    .select   (select),
    .osc      (osc)
  );

  always #5 int_osc = ~int_osc;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [3:0] m_dig [2];   // [0] = right (newest), [1] = left
  bit         m_vld [2];
  int         m_t;         // clock edges since reset release
  logic [1:0] m_osc;
  logic [3:0] m_sel;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: predict outputs from the phase before the edge, apply the
  // key shift, then compare just after the edge.
  task automatic step();
    int ph;
    @(posedge int_osc);
    ph = m_t % PERIOD;
    m_t++;
    if (ph < RC) begin
      m_osc = m_vld[0] ? 2'b10 : 2'b11;
      m_sel = m_dig[0];
    end else if (ph < RC + BC) begin
      m_osc = 2'b11;
      m_sel = m_dig[1];
    end else if (ph < 2 * RC + BC) begin
      m_osc = m_vld[1] ? 2'b01 : 2'b11;
      m_sel = m_dig[1];
    end else begin
      m_osc = 2'b11;
      m_sel = m_dig[0];
    end
    if (key_valid) begin
      m_dig[1] = m_dig[0];
      m_vld[1] = m_vld[0];
      m_dig[0] = key_code;
      m_vld[0] = 1'b1;
    end
    #1;
    chk("osc", int'(osc), int'(m_osc));
    chk("select", int'(select), int'(m_sel));
    chk("osc_not_00", int'(osc == 2'b00), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    key_valid = 1'b0;
    #1;
    m_dig[0] = 4'h0; m_dig[1] = 4'h0;
    m_vld[0] = 1'b0; m_vld[1] = 1'b0;
    m_t = 0;
    chk("rst_osc_async", int'(osc), 2'b11);
    chk("rst_sel_async", int'(select), 0);
    repeat (2) @(posedge int_osc);
    #1;
    chk("rst_osc_held", int'(osc), 2'b11);
    chk("rst_sel_held", int'(select), 0);
    #2;
    reset = 1'b1;
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
    key_code  = 4'($urandom);   // must be ignored while key_valid=0
  endtask

  typedef struct {
    int          n;
    logic [11:0] keys;     // key i in keys[4*i +: 4]
    logic [3:0]  sel_r;
    logic [1:0]  osc_r;
    logic [3:0]  sel_l;
    logic [1:0]  osc_l;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int rises [$];
    int n10;
    logic [1:0] prev;
    int bad;

    vecs[0] = '{n: 0, keys: 12'h000, sel_r: 4'h0, osc_r: 2'b11, sel_l: 4'h0, osc_l: 2'b11};
    vecs[1] = '{n: 1, keys: 12'h007, sel_r: 4'h7, osc_r: 2'b10, sel_l: 4'h0, osc_l: 2'b11};
    vecs[2] = '{n: 2, keys: 12'h0A3, sel_r: 4'hA, osc_r: 2'b10, sel_l: 4'h3, osc_l: 2'b01};
    vecs[3] = '{n: 3, keys: 12'h321, sel_r: 4'h3, osc_r: 2'b10, sel_l: 4'h2, osc_l: 2'b01};
    vecs[4] = '{n: 2, keys: 12'h0F0, sel_r: 4'hF, osc_r: 2'b10, sel_l: 4'h0, osc_l: 2'b01};

    #2;
    // Table: keys on consecutive cycles, then probe mid SHOW_R and mid SHOW_L
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) press(vecs[v].keys[4*i +: 4]);
      while (m_t < PERIOD + RC / 2 + 1) step();
      chk("tbl_sel_show_r", int'(select), int'(vecs[v].sel_r));
      chk("tbl_osc_show_r", int'(osc), int'(vecs[v].osc_r));
      while (m_t < PERIOD + RC + BC + RC / 2 + 1) step();
      chk("tbl_sel_show_l", int'(select), int'(vecs[v].sel_l));
      chk("tbl_osc_show_l", int'(osc), int'(vecs[v].osc_l));
    end

    // Idle after reset: dark and zero for 40 cycles
    do_reset();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (osc != 2'b11 || select != 4'h0) bad++;
    end
    chk("idle_dark_cycles", bad, 0);

    // Single key: period and lit duty measured from osc
    do_reset();
    press(4'h7);
    prev = osc;
    n10 = 0;
    while (m_t < 3 * PERIOD + 1) begin
      step();
      if (osc == 2'b10 && prev != 2'b10) rises.push_back(m_t);
      if (osc == 2'b10 && m_t > PERIOD && m_t <= 2 * PERIOD) n10++;
      prev = osc;
    end
    if (rises.size() >= 2) chk("scan_period", rises[$] - rises[$-1], PERIOD);
    else chk("scan_period_rises", rises.size(), 2);
    chk("lit_cycles_per_period", n10, RC);

    // Key on the SHOW_R -> BLANK_RL transition edge
    do_reset();
    press(4'h5);
    while (m_t < RC - 1) step();
    press(4'h9);
    chk("xition_osc_last_show", int'(osc), 2'b10);
    step();
    chk("xition_blank1_osc", int'(osc), 2'b11);
    chk("xition_blank1_sel", int'(select), 4'h5);
    step();
    chk("xition_blank2_osc", int'(osc), 2'b11);
    step();
    chk("xition_show_l_osc", int'(osc), 2'b01);
    chk("xition_show_l_sel", int'(select), 4'h5);

    // Asynchronous reset mid SHOW_L with left=3, right=A
    do_reset();
    press(4'h3);
    press(4'hA);
    while (m_t < RC + BC + 5) step();
    chk("pre_rst_osc", int'(osc), 2'b01);
    chk("pre_rst_sel", int'(select), 4'h3);
    #2;
    do_reset();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (osc != 2'b11 || select != 4'h0) bad++;
    end
    chk("post_rst_idle", bad, 0);

    // Randomized traffic against the model, with occasional resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      key_valid = ($urandom_range(0, 4) == 0);
      key_code  = 4'($urandom);
      step();
      key_valid = 1'b0;
      if ($urandom_range(0, 249) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: REFRESH_CYCLES, default 24000, number of int_osc cycles each digit is lit per visit (legal range 2..65536).
REQ-002 Parameter: BLANK_CYCLES, default 480, number of int_osc cycles both digits are dark between visits (legal range 1..65536).
REQ-003 Port: int_osc  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: key_valid  input  1  single-cycle pulse; one debounced key press is available on key_code.
REQ-006 Port: key_code  input  4  hex value of the pressed key; sampled only when key_valid=1.
REQ-007 Port: select  output  4  hex value presented to the shared seven-segment decoder; registered.
REQ-008 Port: osc  output  2  active-low digit enables, osc[0]=right digit, osc[1]=left digit; registered.

Function
REQ-009 The block SHALL hold two 4-bit digit registers, right (newest) and left (previous), plus one valid flag for each.
REQ-010 On a cycle with key_valid=1, left SHALL take the old right value, right SHALL take key_code, left_valid SHALL take right_valid, and right_valid SHALL be set to 1.
REQ-011 The block SHALL run a 4-state scan FSM: SHOW_R -> BLANK_RL -> SHOW_L -> BLANK_LR -> SHOW_R.
REQ-012 A 16-bit dwell counter SHALL clear on every state entry and advance by 1 each cycle.
REQ-013 SHOW_R and SHOW_L SHALL last exactly REFRESH_CYCLES cycles each.
REQ-014 BLANK_RL and BLANK_LR SHALL last exactly BLANK_CYCLES cycles each.
REQ-015 One complete scan period SHALL therefore be 2*(REFRESH_CYCLES+BLANK_CYCLES) cycles.
REQ-016 Target digit: right in SHOW_R and BLANK_LR; left in SHOW_L and BLANK_RL. The digit is retargeted at blank entry so the decoder settles before its anode turns on.
REQ-017 Each cycle, select SHALL register the current value of the target digit register, giving 1-cycle latency.
REQ-018 A key press arriving while a digit is lit SHALL appear on select 2 cycles after the key_valid cycle, with no wait for the next scan.
REQ-019 osc SHALL register 2'b10 in SHOW_R when right_valid=1, and 2'b01 in SHOW_L when left_valid=1.
REQ-020 In all other cases osc SHALL register 2'b11: both blank states, and any show state whose digit valid flag is 0.
REQ-021 osc SHALL never be 2'b00 in any cycle.
REQ-022 When key_valid coincides with an FSM transition, both updates SHALL take effect in the same cycle, with no lost key and no extra or shortened dwell.
REQ-023 Back-to-back key_valid pulses on consecutive cycles SHALL each shift once.
REQ-024 key_code SHALL be ignored whenever key_valid=0.

Reset
REQ-025 While reset=0, the block SHALL force:
- FSM=SHOW_R, dwell counter=0;
- right=left=4'h0, right_valid=left_valid=0;
- select=4'h0, osc=2'b11.
REQ-026 Reset SHALL take effect immediately, including mid-dwell and mid-blank, and SHALL discard any stored digits.
REQ-027 After reset deasserts, the first SHOW_R SHALL last a full REFRESH_CYCLES cycles counted from the first active clock edge.

Verification (REFRESH_CYCLES=8, BLANK_CYCLES=2)
REQ-028 Reset, then no keys for 40 cycles -> osc stays 2'b11 and select stays 4'h0 throughout, and the FSM period measures 20 cycles.
REQ-029 key_valid with key_code=4'h7 -> right=7, and select=7 during SHOW_R; osc=2'b10 for 8 of every 20 cycles and 2'b11 otherwise.
REQ-030 Keys 4'h3 then 4'hA -> left=3, right=A, and osc alternates 2'b10 (8 cycles), 2'b11 (2), 2'b01 (8), 2'b11 (2).
- select is A during SHOW_R and 3 during SHOW_L, switching within BLANK.
REQ-031 key_valid asserted exactly on the SHOW_R -> BLANK_RL transition cycle -> the shift occurs, BLANK still lasts 2 cycles, and osc never shows 2'b00.
REQ-032 reset pulsed low mid-SHOW_L with left=3 and right=A -> osc=2'b11 and select=0 asynchronously.
- After release, the block behaves as in REQ-028.
REQ-033 Keys 4'h1, 4'h2, 4'h3 on three consecutive cycles -> left=2, right=3, both valid.
